// File: rtl/lcd_message_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// lcd_message_arbiter_pkg
//   Shared definitions for the LCD message arbiter and its clients:
//   requester indices, arbiter state encoding and the LCD message codes
//   understood by the LCD driver.
// ----------------------------------------------------------------------------
package lcd_message_arbiter_pkg;

    // Requester slots on the arbiter's req/msg/gnt/ack buses.
    localparam int REQ_PC   = 0;   // process control
    localparam int REQ_AC   = 1;   // access control
    localparam int REQ_GAME = 2;   // game
    localparam int REQ_SB   = 3;   // scoreboard

    localparam int LCD_MSG_W = 4;

    // Message codes shared with the LCD driver.
    localparam logic [LCD_MSG_W-1:0] MSG_BLANK      = 4'h0;
    localparam logic [LCD_MSG_W-1:0] MSG_PROC_IDLE  = 4'h1;
    localparam logic [LCD_MSG_W-1:0] MSG_PROC_RUN   = 4'h2;
    localparam logic [LCD_MSG_W-1:0] MSG_PROC_DONE  = 4'h3;
    localparam logic [LCD_MSG_W-1:0] MSG_ACCESS_OK  = 4'h4;
    localparam logic [LCD_MSG_W-1:0] MSG_ACCESS_BAD = 4'h5;
    localparam logic [LCD_MSG_W-1:0] MSG_GAME_START = 4'h6;
    localparam logic [LCD_MSG_W-1:0] MSG_GAME_OVER  = 4'h7;
    localparam logic [LCD_MSG_W-1:0] MSG_SCORE      = 4'h8;
    localparam logic [LCD_MSG_W-1:0] MSG_HIGH_SCORE = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/lcd_message_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
//   Combinational round-robin picker. Searches req starting at rr_ptr,
//   ascending and wrapping from N_REQ-1 back to 0; the first set bit wins.
//   Ports:
//     req        in   N_REQ  request vector
//     rr_ptr     in   IDX_W  index with highest priority this round
//     win_onehot out  N_REQ  one-hot winner (zero when no request)
//     win_idx    out  IDX_W  winner index (zero when no request)
//     win_valid  out  1      at least one request present
// ----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            int cand;
            cand = (int'(rr_ptr) + off) % N_REQ;
            if (!win_valid && req[cand]) begin
                win_valid        = 1'b1;
                win_idx          = IDX_W'(cand);
                win_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_message_arbiter.sv
// ----------------------------------------------------------------------------
// lcd_message_arbiter
//   Shares the character-LCD message select bus between N_REQ requesters.
//   A round-robin winner has its message code latched onto lcd_sel and keeps
//   the grant for DWELL_CYCLES non-busy cycles, then gets a one-cycle ack
//   followed by a mandatory idle gap before the next arbitration.
//   Ports:
//     clk      in   1            system clock
//     rst      in   1            synchronous reset, active-high
//     req      in   N_REQ        per-requester request level
//     msg      in   N_REQ*MSG_W  message codes, requester i at [i*MSG_W +: MSG_W]
//     lcd_busy in   1            LCD driver mid-write; freezes the dwell counter
//     gnt      out  N_REQ        one-hot grant
//     ack      out  N_REQ        one-cycle completion pulse
//     lcd_sel  out  MSG_W        message select to the LCD driver
//     arb_busy out  1            arbiter is not idle
// ----------------------------------------------------------------------------
module lcd_message_arbiter
    import lcd_message_arbiter_pkg::*;
#(
    parameter int               N_REQ        = 4,
    parameter int               MSG_W        = 4,
    parameter int               DWELL_CYCLES = 50000000,
    parameter logic [MSG_W-1:0] DEFAULT_MSG  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*MSG_W-1:0] msg,
    input  logic                   lcd_busy,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [MSG_W-1:0]       lcd_sel,
    output logic                   arb_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  win_q,   win_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [MSG_W-1:0]  lcd_sel_q, lcd_sel_d;

    logic [N_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_valid  (pick_valid)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            lcd_sel_q <= DEFAULT_MSG;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            lcd_sel_q <= lcd_sel_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        lcd_sel_d = lcd_sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d   = ST_DWELL;
                    win_d     = pick_idx;
                    cnt_d     = CNT_LOAD;
                    // Only the winner's code is captured; msg is not looked
                    // at again until the next arbitration.
                    lcd_sel_d = msg[pick_idx*MSG_W +: MSG_W];
                end
            end
            ST_DWELL: begin
                if (!lcd_busy) begin
                    if (cnt_q == '0) begin
                        state_d  = ST_GAP;
                        // Winner drops to lowest priority for the next round.
                        rr_ptr_d = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so they change one
    // cycle after the decision that causes them.
    always_comb begin
        gnt      = '0;
        ack      = '0;
        arb_busy = (state_q != ST_IDLE);
        if (state_q == ST_DWELL) begin
            gnt[win_q] = 1'b1;
        end
        if (state_q == ST_GAP) begin
            ack[win_q] = 1'b1;
        end
    end

    assign lcd_sel = lcd_sel_q;

    // pick_onehot is kept on the picker for other users (button routing).
    logic unused_pick;
    assign unused_pick = ^pick_onehot;

endmodule

// File: tb/tb_lcd_message_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lcd_message_arbiter
//   Directed bench for lcd_message_arbiter with DWELL_CYCLES=4. Inputs are
//   driven 1 ns after each rising edge and outputs are checked at the same
//   point, i.e. after the registers have updated for that edge.
// ----------------------------------------------------------------------------
module tb_lcd_message_arbiter;

    localparam int               N_REQ   = 4;
    localparam int               MSG_W   = 4;
    localparam int               DWELL   = 4;
    localparam logic [MSG_W-1:0] DEF_MSG = 4'h0;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*MSG_W-1:0] msg;
    logic                   lcd_busy;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [MSG_W-1:0]       lcd_sel;
    logic                   arb_busy;

    int n_checks = 0;
    int n_pass   = 0;

    lcd_message_arbiter #(
        .N_REQ        (N_REQ),
        .MSG_W        (MSG_W),
        .DWELL_CYCLES (DWELL),
        .DEFAULT_MSG  (DEF_MSG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .msg      (msg),
        .lcd_busy (lcd_busy),
        .gnt      (gnt),
        .ack      (ack),
        .lcd_sel  (lcd_sel),
        .arb_busy (arb_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-24s ok   got=%0h", tag, obs);
        end else begin
            $display("FAIL %-24s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        msg      = '0;
        lcd_busy = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_gnt",      32'(gnt),      32'h0);
        check("rst_ack",      32'(ack),      32'h0);
        check("rst_lcd_sel",  32'(lcd_sel),  32'(DEF_MSG));
        check("rst_arb_busy", 32'(arb_busy), 32'h0);
        rst = 1'b0;
        step();
        check("idle_no_req_gnt", 32'(gnt), 32'h0);

        // ---------------- 1: single request from requester 2 ----------------
        req = 4'b0100;
        msg = 16'h0700;
        step();
        req = 4'b0000;
        msg = 16'h0000;
        for (int k = 0; k < DWELL; k++) begin
            check($sformatf("t1_gnt_c%0d", k), 32'(gnt), 32'h4);
            check($sformatf("t1_sel_c%0d", k), 32'(lcd_sel), 32'h7);
            step();
        end
        check("t1_gap_ack",  32'(ack), 32'h4);
        check("t1_gap_gnt",  32'(gnt), 32'h0);
        check("t1_gap_busy", 32'(arb_busy), 32'h1);
        step();
        check("t1_idle_ack",  32'(ack), 32'h0);
        check("t1_idle_sel",  32'(lcd_sel), 32'h7);
        check("t1_idle_busy", 32'(arb_busy), 32'h0);

        // ---------------- 2: all four requesting from reset ----------------
        req = 4'b1111;
        msg = 16'hDCBA;
        do_reset();
        step();
        begin
            int order [5] = '{0, 1, 2, 3, 0};
            logic [3:0] codes [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
            for (int g = 0; g < 5; g++) begin
                for (int k = 0; k < DWELL; k++) begin
                    check($sformatf("t2_g%0d_gnt_c%0d", g, k), 32'(gnt), 32'(1 << order[g]));
                    step();
                end
                check($sformatf("t2_g%0d_sel", g), 32'(lcd_sel), 32'(codes[order[g]]));
                check($sformatf("t2_g%0d_ack", g), 32'(ack), 32'(1 << order[g]));
                check($sformatf("t2_g%0d_gapgnt", g), 32'(gnt), 32'h0);
                step();
                check($sformatf("t2_g%0d_idlegnt", g), 32'(gnt), 32'h0);
                check($sformatf("t2_g%0d_idleack", g), 32'(ack), 32'h0);
                if (g == 4) req = 4'b0000;
                step();
            end
        end
        // rr_ptr is now 1; let the arbiter settle idle.
        step();
        check("t2_end_busy", 32'(arb_busy), 32'h0);

        // ---------------- 3: lcd_busy stretches requester 1 ----------------
        req = 4'b0010;
        msg = 16'h0050;
        step();
        req = 4'b0000;
        for (int k = 0; k < DWELL + 3; k++) begin
            lcd_busy = (k < 3);
            check($sformatf("t3_gnt_c%0d", k), 32'(gnt), 32'h2);
            check($sformatf("t3_ack_c%0d", k), 32'(ack), 32'h0);
            step();
        end
        lcd_busy = 1'b0;
        check("t3_ack",     32'(ack), 32'h2);
        check("t3_gap_gnt", 32'(gnt), 32'h0);
        check("t3_sel",     32'(lcd_sel), 32'h5);
        step();
        check("t3_idle_ack", 32'(ack), 32'h0);

        // ---------------- 4: requester 3 drops req mid-dwell ----------------
        req = 4'b1000;
        msg = 16'h8000;
        step();
        step();
        req = 4'b0000;
        // first dwell cycle was the step above
        for (int k = 1; k < DWELL; k++) begin
            check($sformatf("t4_gnt_c%0d", k), 32'(gnt), 32'h8);
            step();
        end
        check("t4_ack",     32'(ack), 32'h8);
        check("t4_sel",     32'(lcd_sel), 32'h8);
        step();
        // rr_ptr must be 0 now: requester 0 beats requester 3.
        req = 4'b1001;
        msg = 16'h1002;
        step();
        check("t4_rr_wrap_gnt", 32'(gnt), 32'h1);

        // ---------------- 6: msg change during requester 0's grant ----------------
        req = 4'b0000;
        msg = 16'h1009;
        for (int k = 0; k < DWELL; k++) begin
            check($sformatf("t6_sel_c%0d", k), 32'(lcd_sel), 32'h2);
            step();
        end
        check("t6_ack",     32'(ack), 32'h1);
        check("t6_gap_sel", 32'(lcd_sel), 32'h2);
        step();
        check("t6_idle_sel", 32'(lcd_sel), 32'h2);
        req = 4'b0001;
        step();
        req = 4'b0000;
        check("t6_regrant_gnt", 32'(gnt), 32'h1);
        check("t6_regrant_sel", 32'(lcd_sel), 32'h9);
        for (int k = 0; k < DWELL + 1; k++) step();

        // ---------------- 5: reset during dwell ----------------
        req = 4'b0100;
        msg = 16'h0600;
        step();
        req = 4'b0000;
        check("t5_gnt_c0", 32'(gnt), 32'h4);
        step();
        check("t5_gnt_c1", 32'(gnt), 32'h4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_gnt",  32'(gnt), 32'h0);
        check("t5_rst_ack",  32'(ack), 32'h0);
        check("t5_rst_sel",  32'(lcd_sel), 32'(DEF_MSG));
        check("t5_rst_busy", 32'(arb_busy), 32'h0);
        begin
            logic [N_REQ-1:0] ack_seen;
            ack_seen = '0;
            for (int k = 0; k < 2 * DWELL; k++) begin
                step();
                ack_seen |= ack;
            end
            check("t5_no_ack", 32'(ack_seen), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
